// File: rtl/apb_mem_pkg.sv
// Shared types and constants for the APB memory slave.
package apb_mem_pkg;

  localparam int ERR_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_mem_array.sv
// Word-organised storage with per-byte write enables, cleared on reset.
module apb_mem_array
  import apb_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [DATA_W/8-1:0]      be,
  input  logic [$clog2(DEPTH)-1:0] widx,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] ridx,
  output logic [DATA_W-1:0]        rdata
);

  localparam int BYTES = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (be[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/apb_mem_slave.sv
// APB slave fronting a byte-strobed memory, with programmable wait states
// and a saturating error-response counter.
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_W      = 32
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [ADDR_W-1:0]    PADDR,
  input  logic [DATA_W-1:0]    PWDATA,
  input  logic [DATA_W/8-1:0]  PSTRB,
  output logic [DATA_W-1:0]    PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LIMIT = DEPTH * BYTES;

  apb_state_e        state_q, state_d;
  logic [3:0]        cnt_q;
  logic [IDX_W-1:0]  idx, idx_q;
  logic              addr_err, err_q, write_q;
  logic [DATA_W-1:0] mem_rdata, rdata_q;
  logic              ready, complete, mem_we;

  assign idx      = PADDR[IDX_W+OFF_W-1 : OFF_W];
  assign addr_err = ({1'b0, PADDR} >= (ADDR_W+1)'(LIMIT)) ||
                    ((PADDR & ADDR_W'(BYTES - 1)) != '0);

  assign ready    = (state_q == ACCESS) && (cnt_q == 4'(WAIT_CYCLES));
  // Dropping PSEL on the final access cycle is treated as an abort, not a completion.
  assign complete = ready && PSEL;
  assign mem_we   = complete && write_q && !err_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (PSEL && !PENABLE) state_d = SETUP;
      SETUP:   state_d = PSEL ? ACCESS : IDLE;
      ACCESS: begin
        if (!PSEL)      state_d = IDLE;
        else if (ready) state_d = PENABLE ? IDLE : SETUP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ACCESS && !ready) cnt_q <= cnt_q + 4'd1;
      else                             cnt_q <= '0;
      // Transfer attributes are frozen as the access phase begins.
      if (state_q == SETUP) begin
        rdata_q <= mem_rdata;
        err_q   <= addr_err;
        write_q <= PWRITE;
        idx_q   <= idx;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                              err_count <= '0;
    else if (complete && err_q && err_count != '1) err_count <= err_count + 1'b1;
  end

  assign PREADY  = ready;
  assign PSLVERR = ready && err_q;
  assign PRDATA  = (ready && !write_q && !err_q) ? rdata_q : '0;

  apb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .we    (mem_we),
    .be    (PSTRB),
    .widx  (idx_q),
    .wdata (PWDATA),
    .ridx  (idx),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: three instances with 0, 3 and 2 wait states sharing one bus.
module tb_apb_mem_slave;

  logic        PCLK    = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE  = 1'b0;
  logic [31:0] PADDR   = '0;
  logic [31:0] PWDATA  = '0;
  logic [3:0]  PSTRB   = '0;
  logic        psel    [3];
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];
  logic [15:0] errc    [3];

  always #5 PCLK = ~PCLK;

  apb_mem_slave #(.WAIT_CYCLES(0)) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .err_count(errc[0]));

  apb_mem_slave #(.WAIT_CYCLES(3)) dut1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .err_count(errc[1]));

  apb_mem_slave #(.WAIT_CYCLES(2)) dut2 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[2]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata[2]), .PREADY(pready[2]),
    .PSLVERR(pslverr[2]), .err_count(errc[2]));

  typedef struct {
    logic [31:0] rdata;
    logic        slverr;
    int unsigned lat;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        slverr;
  } vec_t;

  exp_t        sb [$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned errm [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int unsigned wait_of(input int w);
    return (w == 0) ? 0 : (w == 1) ? 3 : 2;
  endfunction

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic [31:0] rdata, input logic slverr);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.rdata = rdata; v.slverr = slverr;
    return v;
  endfunction

  // mode 0: idle cycle then setup; 1: chained from previous transfer; 2: setup immediately.
  task automatic xfer(input int w, input int mode, input bit chain, input logic wr,
                      input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input logic [31:0] exp_rd, input logic exp_err);
    exp_t        e;
    int unsigned n;
    bit          done;
    e.rdata  = exp_rd;
    e.slverr = exp_err;
    e.lat    = wait_of(w) + 1;
    if (mode == 0) @(negedge PCLK);
    if (mode == 1) begin
      @(negedge PCLK);
      PENABLE = 1'b1;
    end else begin
      psel[w] = 1'b1;
      PENABLE = 1'b0;
    end
    PWRITE = wr; PADDR = addr; PWDATA = data; PSTRB = strb;
    sb.push_back(e);
    if (mode != 1) begin
      @(negedge PCLK);
      PENABLE = 1'b1;
    end
    check($sformatf("dut%0d pready_in_setup", w), 32'(pready[w]), 32'd0);
    n = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      @(negedge PCLK);
      n++;
      if (pready[w]) done = 1'b1;
      else check($sformatf("dut%0d prdata_while_waiting", w), prdata[w], 32'd0);
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL dut%0d pready_timeout: got 0 after %0d cycles expected 1", w, n);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      check($sformatf("dut%0d latency @%h", w, addr), n, e.lat);
      check($sformatf("dut%0d prdata @%h", w, addr), prdata[w], e.rdata);
      check($sformatf("dut%0d pslverr @%h", w, addr), 32'(pslverr[w]), 32'(e.slverr));
      check($sformatf("dut%0d err_count", w), 32'(errc[w]), errm[w]);
      if (e.slverr) errm[w]++;
    end
    if (chain) begin
      PENABLE = 1'b0;
    end else begin
      @(negedge PCLK);
      psel[w] = 1'b0;
      PENABLE = 1'b0;
    end
  endtask

  vec_t tbl [11];

  initial begin
    tbl[0]  = mk(1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0);
    tbl[1]  = mk(1'b0, 32'h010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0);
    tbl[2]  = mk(1'b1, 32'h010, 32'h11223344, 4'hF, 32'h0,        1'b0);
    tbl[3]  = mk(1'b1, 32'h010, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0);
    tbl[4]  = mk(1'b0, 32'h010, 32'h0,        4'h0, 32'h11BB33DD, 1'b0);
    tbl[5]  = mk(1'b0, 32'h400, 32'h0,        4'h0, 32'h0,        1'b1);
    tbl[6]  = mk(1'b1, 32'h013, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1);
    tbl[7]  = mk(1'b0, 32'h010, 32'h0,        4'h0, 32'h11BB33DD, 1'b0);
    tbl[8]  = mk(1'b0, 32'h3FC, 32'h0,        4'h0, 32'h0,        1'b0);
    tbl[9]  = mk(1'b1, 32'h3FC, 32'h12345678, 4'hF, 32'h0,        1'b0);
    tbl[10] = mk(1'b0, 32'h3FD, 32'h0,        4'h0, 32'h0,        1'b1);

    for (int w = 0; w < 3; w++) begin
      psel[w] = 1'b0;
      errm[w] = 0;
    end

    repeat (3) @(negedge PCLK);
    for (int w = 0; w < 3; w++) begin
      check($sformatf("dut%0d reset pready", w), 32'(pready[w]), 32'd0);
      check($sformatf("dut%0d reset pslverr", w), 32'(pslverr[w]), 32'd0);
      check($sformatf("dut%0d reset prdata", w), prdata[w], 32'd0);
      check($sformatf("dut%0d reset err_count", w), 32'(errc[w]), 32'd0);
    end
    PRESETn = 1'b1;

    for (int i = 0; i < 11; i++)
      xfer(0, 0, 1'b0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, tbl[i].rdata, tbl[i].slverr);
    xfer(0, 0, 1'b0, 1'b0, 32'h3FC, 32'h0, 4'h0, 32'h12345678, 1'b0);

    // Three access wait cycles before PREADY.
    xfer(1, 0, 1'b0, 1'b1, 32'h010, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    xfer(1, 0, 1'b0, 1'b0, 32'h010, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
    xfer(1, 0, 1'b0, 1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1);

    // PSEL dropped during ACCESS: write to 0x20 must be discarded.
    xfer(2, 0, 1'b0, 1'b1, 32'h020, 32'h55AA55AA, 4'hF, 32'h0, 1'b0);
    @(negedge PCLK);
    psel[2] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h020;
    PWDATA = 32'hFFFFFFFF; PSTRB = 4'hF;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    check("dut2 abort pready_before_drop", 32'(pready[2]), 32'd0);
    psel[2] = 1'b0; PENABLE = 1'b0;
    repeat (3) begin
      @(negedge PCLK);
      check("dut2 abort pready_idle", 32'(pready[2]), 32'd0);
    end
    xfer(2, 0, 1'b0, 1'b0, 32'h020, 32'h0, 4'h0, 32'h55AA55AA, 1'b0);

    // Reset asserted on the completing cycle of a write.
    @(negedge PCLK);
    psel[0] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h010;
    PWDATA = 32'h99999999; PSTRB = 4'hF;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    check("dut0 pready_before_reset", 32'(pready[0]), 32'd1);
    PRESETn = 1'b0;
    #1;
    for (int w = 0; w < 3; w++) begin
      check($sformatf("dut%0d midreset pready", w), 32'(pready[w]), 32'd0);
      check($sformatf("dut%0d midreset prdata", w), prdata[w], 32'd0);
      check($sformatf("dut%0d midreset err_count", w), 32'(errc[w]), 32'd0);
      errm[w] = 0;
      psel[w] = 1'b0;
    end
    PENABLE = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    xfer(0, 2, 1'b0, 1'b0, 32'h010, 32'h0, 4'h0, 32'h0, 1'b0);

    // Back-to-back transfers with no IDLE cycle in between.
    xfer(0, 0, 1'b1, 1'b1, 32'h040, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0);
    xfer(0, 1, 1'b1, 1'b0, 32'h040, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0);
    xfer(0, 1, 1'b1, 1'b1, 32'h044, 32'h01020304, 4'h3, 32'h0, 1'b0);
    xfer(0, 1, 1'b1, 1'b0, 32'h047, 32'h0, 4'h0, 32'h0, 1'b1);
    xfer(0, 1, 1'b0, 1'b0, 32'h044, 32'h0, 4'h0, 32'h00000304, 1'b0);

    @(negedge PCLK);
    for (int w = 0; w < 3; w++)
      check($sformatf("dut%0d final err_count", w), 32'(errc[w]), errm[w]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
